// File: rtl/lsu_wb_if.sv
// lsu_wb_if: groups the LSU issue, write-back and memory-bus signals into one bundle.
// Latency: none. This is wiring only; the i_/o_ prefixes are seen from the LSU side.
// Backpressure: o_stall holds the core. The bus request is held until i_mem_ack arrives.
interface lsu_wb_if;
    // issue side (from decode / ALU address path)
    logic        i_valid;
    logic        i_is_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic [4:0]  i_rd_addr;
    // pipeline control and regfile write-back
    logic        o_stall;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_wren;
    // memory bus
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_misaligned;

    // LSU side
    modport slave (
        input  i_valid, i_is_store, i_funct3, i_addr, i_st_data, i_rd_addr,
        input  i_mem_ack, i_mem_rdata,
        output o_stall, o_rd_addr, o_rd_data, o_rd_wren,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        output o_misaligned
    );

    // core / memory side
    modport master (
        output i_valid, i_is_store, i_funct3, i_addr, i_st_data, i_rd_addr,
        output i_mem_ack, i_mem_rdata,
        input  o_stall, o_rd_addr, o_rd_data, o_rd_wren,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        input  o_misaligned
    );
endinterface

// File: rtl/lsu_wb.sv
// lsu_wb: turns a load or store into one memory-bus access and produces the regfile write-back.
// Latency: 3 cycles minimum (issue, REQ with ack, RESP). Each bus wait cycle adds 1.
// Backpressure: o_stall is high while an access is outstanding. Optional LSU_MISALIGN_CHECK_EN traps misaligned H/W accesses.
module lsu_wb #(
    parameter int XLEN    = 32,
    parameter int ACK_TMO = 0
) (
    input  logic      i_clk,
    input  logic      i_rst,
    lsu_wb_if.slave   bus
);
    localparam int CW = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t           r_state;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;
    logic [4:0]       r_rd;
    logic [CW-1:0]    r_tmo_cnt;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [XLEN-1:0]  r_mem_addr;
    logic [XLEN-1:0]  r_mem_wdata;
    logic [3:0]       r_mem_bmask;
    logic [4:0]       r_rd_addr;
    logic [XLEN-1:0]  r_rd_data;
    logic             r_rd_wren;

    logic [1:0]       w_off;
    logic [XLEN-1:0]  w_wdata;
    logic [3:0]       w_bmask;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [XLEN-1:0]  w_ld_data;

    assign w_off = bus.i_addr[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
    logic             r_misaligned;
    logic             w_misalign;
    // Halfwords must be 2-byte aligned. Words, including undefined funct3, must be 4-byte aligned.
    assign w_misalign = (bus.i_funct3[1:0] == 2'b01) ? w_off[0]
                      : (bus.i_funct3[1:0] == 2'b00) ? 1'b0
                      : (w_off != 2'b00);
    assign bus.o_misaligned = r_misaligned;
`else
    assign bus.o_misaligned = 1'b0;
`endif

    // Store lane replication and byte mask. Loads always read the full word.
    always_comb begin
        w_wdata = bus.i_st_data;
        w_bmask = 4'b1111;
        if (bus.i_is_store) begin
            case (bus.i_funct3[1:0])
                2'b00: begin
                    w_wdata = {4{bus.i_st_data[7:0]}};
                    w_bmask = 4'b0001 << w_off;
                end
                2'b01: begin
                    w_wdata = {2{bus.i_st_data[15:0]}};
                    w_bmask = 4'b0011 << {w_off[1], 1'b0};
                end
                default: begin
                    w_wdata = bus.i_st_data;
                    w_bmask = 4'b1111;
                end
            endcase
        end
    end

    // Select the addressed byte or halfword of the returned word, then extend it.
    always_comb begin
        w_byte = bus.i_mem_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = bus.i_mem_rdata[15:8];
            2'd2:    w_byte = bus.i_mem_rdata[23:16];
            2'd3:    w_byte = bus.i_mem_rdata[31:24];
            default: w_byte = bus.i_mem_rdata[7:0];
        endcase
        w_half = r_off[1] ? bus.i_mem_rdata[31:16] : bus.i_mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = bus.i_mem_rdata;
        endcase
    end

    // Access sequencer: capture on issue, hold the request until ack or timeout, pulse write-back.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_rd        <= 5'd0;
            r_tmo_cnt   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_bmask <= 4'd0;
            r_rd_addr   <= 5'd0;
            r_rd_data   <= '0;
            r_rd_wren   <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        r_is_store <= bus.i_is_store;
                        r_funct3   <= bus.i_funct3;
                        r_off      <= w_off;
                        r_rd       <= bus.i_rd_addr;
                        r_tmo_cnt  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
                        if (w_misalign) begin
                            // Trap without touching the bus.
                            r_misaligned <= 1'b1;
                            r_state      <= S_RESP;
                        end else
`endif
                        begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.i_is_store;
                            r_mem_addr  <= {bus.i_addr[31:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_bmask <= w_bmask;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_RESP;
                        if (!r_is_store) begin
                            r_rd_addr <= r_rd;
                            r_rd_data <= w_ld_data;
                            r_rd_wren <= (r_rd != 5'd0);
                        end
                    end else if ((ACK_TMO > 0) && (r_tmo_cnt == CW'(ACK_TMO - 1))) begin
                        // Abandon the access. RESP still releases the core, but nothing is written back.
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    r_rd_wren <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
                    r_misaligned <= 1'b0;
`endif
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The core stalls in the issue cycle and in every REQ cycle. It advances on the RESP edge.
    assign bus.o_stall     = (r_state == S_IDLE) ? bus.i_valid : (r_state == S_REQ);
    assign bus.o_mem_req   = r_mem_req;
    assign bus.o_mem_we    = r_mem_we;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_wdata = r_mem_wdata;
    assign bus.o_mem_bmask = r_mem_bmask;
    assign bus.o_rd_addr   = r_rd_addr;
    assign bus.o_rd_data   = r_rd_data;
    assign bus.o_rd_wren   = r_rd_wren;
endmodule

// File: tb/tb_lsu_wb.sv
// tb_lsu_wb: directed and randomized loads and stores against an arithmetic reference model.
// Latency: each access is walked cycle by cycle (issue, REQ wait cycles, RESP, back to IDLE).
// Backpressure: ack delay is chosen per access, and stall is checked in every cycle.
module tb_lsu_wb;
    logic i_clk;
    logic i_rst;
    int   checks;
    int   errors;

    logic [31:0] obs_rd_data, obs_mem_addr, obs_mem_wdata;
    logic [4:0]  obs_rd_addr;
    logic [3:0]  obs_bmask;
    logic        obs_wren, obs_we, obs_req, obs_mis;
    int          obs_stall_cnt;

    lsu_wb_if bus();

    lsu_wb dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model written from the RV32I width rules using plain arithmetic.
    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] ref_mask(input bit st, input logic [2:0] f3, input int off);
        if (!st) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << off);
        if (f3 == 3'd1) return 4'(3 << (off & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
        logic [31:0] v;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (rd >> (8 * (off & 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
            return v;
        end
        return rd;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input int off);
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) != 0;
        return off != 0;
    endfunction

    // One complete access. Entered and left at #1 after a rising edge with the DUT in IDLE.
    task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] sd, input logic [4:0] rd,
                             input logic [31:0] rdata, input int dly, input string tag);
        int off;
        bit mis;
        bit e_wren;
        off = int'(addr % 4);
        mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        mis = ref_misaligned(f3, off);
`endif
        e_wren = !st && !mis && (rd != 5'd0);

        bus.i_valid    = 1'b1;
        bus.i_is_store = st;
        bus.i_funct3   = f3;
        bus.i_addr     = addr;
        bus.i_st_data  = sd;
        bus.i_rd_addr  = rd;
        bus.i_mem_ack  = ($urandom_range(0, 3) == 0); // must be ignored in IDLE
        #1;
        chk({tag, "_issue_stall"}, 32'(bus.o_stall), 32'd1);
        @(posedge i_clk); #1;
        bus.i_valid   = 1'b0;
        bus.i_mem_ack = 1'b0;
        bus.i_addr    = $urandom;
        bus.i_st_data = $urandom;
        bus.i_rd_addr = 5'($urandom);

        obs_req = bus.o_mem_req;
        obs_mis = bus.o_misaligned;
        if (mis) begin
            chk({tag, "_mis_req"},   32'(bus.o_mem_req),    32'd0);
            chk({tag, "_mis_flag"},  32'(bus.o_misaligned), 32'd1);
            chk({tag, "_mis_wren"},  32'(bus.o_rd_wren),    32'd0);
            chk({tag, "_mis_stall"}, 32'(bus.o_stall),      32'd0);
            obs_wren = bus.o_rd_wren;
        end else begin
            obs_mem_addr  = bus.o_mem_addr;
            obs_mem_wdata = bus.o_mem_wdata;
            obs_bmask     = bus.o_mem_bmask;
            obs_we        = bus.o_mem_we;
            obs_stall_cnt = 0;
            for (int i = 0; i <= dly; i++) begin
                chk({tag, "_req"},   32'(bus.o_mem_req),   32'd1);
                chk({tag, "_stall"}, 32'(bus.o_stall),     32'd1);
                chk({tag, "_addr"},  bus.o_mem_addr,       addr & 32'hFFFF_FFFC);
                chk({tag, "_we"},    32'(bus.o_mem_we),    32'(st));
                chk({tag, "_mask"},  32'(bus.o_mem_bmask), 32'(ref_mask(st, f3, off)));
                if (st) chk({tag, "_wdata"}, bus.o_mem_wdata, ref_wdata(f3, sd));
                if (bus.o_stall) obs_stall_cnt++;
                if (i == dly) begin
                    bus.i_mem_ack   = 1'b1;
                    bus.i_mem_rdata = rdata;
                end else begin
                    bus.i_mem_rdata = $urandom;
                end
                @(posedge i_clk); #1;
                bus.i_mem_ack   = 1'b0;
                bus.i_mem_rdata = $urandom;
            end
            chk({tag, "_resp_stall"}, 32'(bus.o_stall),     32'd0);
            chk({tag, "_resp_req"},   32'(bus.o_mem_req),   32'd0);
            chk({tag, "_resp_wren"},  32'(bus.o_rd_wren),   32'(e_wren));
            chk({tag, "_resp_mis"},   32'(bus.o_misaligned), 32'd0);
            if (e_wren) begin
                chk({tag, "_rd_data"}, bus.o_rd_data,       ref_load(f3, off, rdata));
                chk({tag, "_rd_addr"}, 32'(bus.o_rd_addr),  32'(rd));
            end
            obs_wren    = bus.o_rd_wren;
            obs_rd_data = bus.o_rd_data;
            obs_rd_addr = bus.o_rd_addr;
        end
        @(posedge i_clk); #1;
        chk({tag, "_idle_wren"}, 32'(bus.o_rd_wren),    32'd0);
        chk({tag, "_idle_mis"},  32'(bus.o_misaligned), 32'd0);
        chk({tag, "_idle_req"},  32'(bus.o_mem_req),    32'd0);
    endtask

    initial begin
        logic [2:0] f3;
        bit         st;
        checks = 0;
        errors = 0;
        i_rst  = 1'b0;
        bus.i_valid = 1'b0; bus.i_is_store = 1'b0; bus.i_funct3 = 3'd0;
        bus.i_addr = 32'd0; bus.i_st_data = 32'd0; bus.i_rd_addr = 5'd0;
        bus.i_mem_ack = 1'b0; bus.i_mem_rdata = 32'd0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_stall", 32'(bus.o_stall),     32'd0);
        chk("rst_req",   32'(bus.o_mem_req),   32'd0);
        chk("rst_we",    32'(bus.o_mem_we),    32'd0);
        chk("rst_addr",  bus.o_mem_addr,       32'd0);
        chk("rst_wdata", bus.o_mem_wdata,      32'd0);
        chk("rst_mask",  32'(bus.o_mem_bmask), 32'd0);
        chk("rst_wren",  32'(bus.o_rd_wren),   32'd0);
        chk("rst_rdat",  bus.o_rd_data,        32'd0);
        chk("rst_rda",   32'(bus.o_rd_addr),   32'd0);
        chk("rst_mis",   32'(bus.o_misaligned), 32'd0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;

        // Reset during REQ drops the request. A late ack must not cause a write.
        bus.i_valid = 1'b1; bus.i_is_store = 1'b0; bus.i_funct3 = 3'd2;
        bus.i_addr = 32'h0000_5000; bus.i_rd_addr = 5'd9;
        @(posedge i_clk); #1;
        bus.i_valid = 1'b0;
        chk("t1_req_before", 32'(bus.o_mem_req), 32'd1);
        i_rst = 1'b0;
        #1;
        chk("t1_req",   32'(bus.o_mem_req), 32'd0);
        chk("t1_stall", 32'(bus.o_stall),   32'd0);
        chk("t1_addr",  bus.o_mem_addr,     32'd0);
        chk("t1_wren",  32'(bus.o_rd_wren), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h1234_5678;
        @(posedge i_clk); #1;
        bus.i_mem_ack = 1'b0;
        chk("t1_ack_wren", 32'(bus.o_rd_wren), 32'd0);
        chk("t1_ack_req",  32'(bus.o_mem_req), 32'd0);
        @(posedge i_clk); #1;
        chk("t1_ack_wren2", 32'(bus.o_rd_wren), 32'd0);

        // LB x5 at byte lane 3
        do_access(1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd5, 32'h80FF_FF11, 0, "t2");
        chk("t2_wren",    32'(obs_wren),     32'd1);
        chk("t2_rd_addr", 32'(obs_rd_addr),  32'd5);
        chk("t2_rd_data", obs_rd_data,       32'hFFFF_FF80);
        chk("t2_stall",   32'(obs_stall_cnt), 32'd1);

        // LHU x7, upper half, ack 4 cycles late
        do_access(1'b0, 3'b101, 32'h0000_2002, 32'd0, 5'd7, 32'hBEEF_1234, 4, "t3");
        chk("t3_rd_data", obs_rd_data,        32'h0000_BEEF);
        chk("t3_stall",   32'(obs_stall_cnt), 32'd5);

        // SB at byte lane 1
        do_access(1'b1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 5'd3, 32'd0, 1, "t4");
        chk("t4_addr",  obs_mem_addr,     32'h0000_3000);
        chk("t4_mask",  32'(obs_bmask),   32'b0010);
        chk("t4_wdata", obs_mem_wdata,    32'hABAB_ABAB);
        chk("t4_we",    32'(obs_we),      32'd1);
        chk("t4_wren",  32'(obs_wren),    32'd0);

        // LW into x0: no write-back
        do_access(1'b0, 3'b010, 32'h0000_0100, 32'd0, 5'd0, 32'hDEAD_BEEF, 2, "t5");
        chk("t5_wren", 32'(obs_wren), 32'd0);

        // LW at a non-word-aligned address
        do_access(1'b0, 3'b010, 32'h0000_4002, 32'd0, 5'd4, 32'hCAFE_F00D, 0, "t6");
`ifdef LSU_MISALIGN_CHECK_EN
        chk("t6_req",  32'(obs_req),  32'd0);
        chk("t6_mis",  32'(obs_mis),  32'd1);
        chk("t6_wren", 32'(obs_wren), 32'd0);
`else
        chk("t6_addr", obs_mem_addr,  32'h0000_4000);
        chk("t6_wren", 32'(obs_wren), 32'd1);
        chk("t6_data", obs_rd_data,   32'hCAFE_F00D);
`endif

        // Randomized mix of loads (all funct3 codes) and stores (B/H/W).
        for (int n = 0; n < 60; n++) begin
            st = ($urandom_range(0, 2) == 0);
            f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            do_access(st, f3, $urandom, $urandom, 5'($urandom), $urandom,
                      $urandom_range(0, 3), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
